// File: rtl/dfm_spi_master.sv
// dfm_spi_master: SPI mode-0 master, sends one command byte (dc=0) then reads RD_BYTES bytes (dc=1).
// Latency: done_o 2*CLK_DIV*(10+8*RD_BYTES) + CLK_DIV*CS_HOLD + 1 cycles after start acceptance.
// Backpressure: none; start_i is sampled only in IDLE, requests while busy are dropped, not queued.
// Optional build macro SPI_MASTER_MISO_SYNC_EN: 2-flop MISO synchronizer, sampling at end of SCLK high.
module dfm_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RD_BYTES = 8,
  parameter int unsigned CS_HOLD  = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start_i,
  input  logic [7:0]  cmd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] rd_data_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  output logic        dc_o,
  input  logic        spi_miso_i
);

  localparam int unsigned DATA_BITS = RD_BYTES * 8;
  localparam int unsigned PAD_BITS  = 64 - DATA_BITS;

  localparam logic [7:0] TMR_LAST  = 8'(CLK_DIV - 1);
  localparam logic [8:0] PAIR_LAST = 9'd1;
  localparam logic [8:0] CMD_LAST  = 9'd7;
  localparam logic [8:0] DATA_LAST = 9'(DATA_BITS - 1);
  localparam logic [8:0] HOLD_LAST = 9'(CS_HOLD - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("dfm_spi_master: CLK_DIV must be 2..255");
  end
  if (RD_BYTES < 1 || RD_BYTES > 8) begin : g_bad_rd_bytes
    $error("dfm_spi_master: RD_BYTES must be 1..8");
  end
  if (CS_HOLD < 1 || CS_HOLD > 15) begin : g_bad_cs_hold
    $error("dfm_spi_master: CS_HOLD must be 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  tmr, tmr_nxt;
  logic        half, half_nxt;      // 0 = SCLK low half-period, 1 = high half-period
  logic [8:0]  bit_cnt, bit_cnt_nxt; // bits in CMD/DATA, half-periods in SETUP/GAP/HOLD
  logic [7:0]  cmd_q;
  logic [63:0] shift_q;
  logic [63:0] rd_data_q;
  logic        tick;
  logic        accept;
  logic        load_result;
  logic        sample;
  logic        miso_use;

  assign tick = (tmr == TMR_LAST);

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;

  if (CLK_DIV < 3) begin : g_bad_sync_div
    $error("dfm_spi_master: CLK_DIV must be >= 3 with the MISO synchronizer");
  end

  // Two-flop synchronizer for a MISO launched from a foreign clock domain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      miso_sync <= 2'b00;
    end else begin
      miso_sync <= {miso_sync[0], spi_miso_i};
    end
  end

  // Sample late in the high half so the synchronizer has settled.
  assign miso_use = miso_sync[1];
  assign sample   = (state == S_DATA) && half && tick;
`else
  // Same-domain loopback: sample in the cycle SCLK rises.
  assign miso_use = spi_miso_i;
  assign sample   = (state == S_DATA) && half && (tmr == 8'd0);
`endif

  // State and timing counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      tmr     <= 8'd0;
      half    <= 1'b0;
      bit_cnt <= 9'd0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      half    <= half_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next-state, counter sequencing and SPI pin values.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = 8'd0;
    half_nxt    = half;
    bit_cnt_nxt = bit_cnt;
    accept      = 1'b0;
    load_result = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    spi_cs_n_o  = 1'b1;
    spi_sclk_o  = 1'b0;
    spi_mosi_o  = 1'b0;
    dc_o        = 1'b0;

    // Half-period timer runs only while a frame is on the wire.
    if (state != S_IDLE && state != S_DONE) begin
      tmr_nxt = tick ? 8'd0 : tmr + 8'd1;
    end

    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          accept      = 1'b1;
          state_nxt   = S_SETUP;
          half_nxt    = 1'b0;
          bit_cnt_nxt = 9'd0;
        end
      end
      S_SETUP: begin
        spi_cs_n_o = 1'b0;
        spi_mosi_o = cmd_q[7];
        if (tick) begin
          if (bit_cnt == PAIR_LAST) begin
            state_nxt   = S_CMD;
            bit_cnt_nxt = 9'd0;
          end else begin
            bit_cnt_nxt = bit_cnt + 9'd1;
          end
        end
      end
      S_CMD: begin
        spi_cs_n_o = 1'b0;
        spi_sclk_o = half;
        // bit k carries cmd[7-k]; 7-k is the 3-bit complement of k
        spi_mosi_o = cmd_q[~bit_cnt[2:0]];
        if (tick) begin
          half_nxt = ~half;
          if (half) begin
            if (bit_cnt == CMD_LAST) begin
              state_nxt   = S_GAP;
              bit_cnt_nxt = 9'd0;
            end else begin
              bit_cnt_nxt = bit_cnt + 9'd1;
            end
          end
        end
      end
      S_GAP: begin
        spi_cs_n_o = 1'b0;
        dc_o       = 1'b1;
        if (tick) begin
          if (bit_cnt == PAIR_LAST) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = 9'd0;
          end else begin
            bit_cnt_nxt = bit_cnt + 9'd1;
          end
        end
      end
      S_DATA: begin
        spi_cs_n_o = 1'b0;
        dc_o       = 1'b1;
        spi_sclk_o = half;
        if (tick) begin
          half_nxt = ~half;
          if (half) begin
            if (bit_cnt == DATA_LAST) begin
              state_nxt   = S_HOLD;
              bit_cnt_nxt = 9'd0;
            end else begin
              bit_cnt_nxt = bit_cnt + 9'd1;
            end
          end
        end
      end
      S_HOLD: begin
        spi_cs_n_o = 1'b0;
        dc_o       = 1'b1;
        if (tick) begin
          if (bit_cnt == HOLD_LAST) begin
            state_nxt   = S_DONE;
            bit_cnt_nxt = 9'd0;
            load_result = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 9'd1;
          end
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, MISO shift register and result register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_q     <= 8'd0;
      shift_q   <= 64'd0;
      rd_data_q <= 64'd0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd_i;
        shift_q <= 64'd0;
      end else if (sample) begin
        shift_q <= {shift_q[62:0], miso_use};
      end
      // Result lands as the FSM enters DONE, so it is valid with done_o.
      if (load_result) begin
        rd_data_q <= shift_q << PAD_BITS;
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_dfm_spi_master.sv
// tb_dfm_spi_master: directed bench for dfm_spi_master (default build and RD_BYTES=2 instance).
// A mode-0 slave model drives MISO on SCLK falling edges and records MOSI/dc on rising edges.
// Expected values are hand-computed constants for each directed vector.
module tb_dfm_spi_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start_a, start_b;
  logic [7:0]  cmd_a, cmd_b;
  logic [1:0]  miso_v = 2'b00;

  logic        busy_a, done_a, sclk_a, mosi_a, cs_a, dc_a;
  logic        busy_b, done_b, sclk_b, mosi_b, cs_b, dc_b;
  logic [63:0] rd_a, rd_b;

  wire [1:0] sclk_w = {sclk_b, sclk_a};
  wire [1:0] mosi_w = {mosi_b, mosi_a};
  wire [1:0] dc_w   = {dc_b, dc_a};
  wire [1:0] done_w = {done_b, done_a};

  int vec_cnt = 0;
  int err_cnt = 0;

  // slave model state, one slot per DUT
  logic [1:0]  clr_req;
  logic [63:0] slv_word [2];
  logic [63:0] slv_data [2];
  logic [1:0]  prev_sclk = 2'b00;
  int          rise_cnt [2];
  int          fall_cnt [2];
  int          done_cnt [2];
  int          dc_err   [2];
  logic [7:0]  mosi_cap [2];

  always #5 sys_clk = ~sys_clk;

  dfm_spi_master dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start_i    (start_a),
    .cmd_i      (cmd_a),
    .busy_o     (busy_a),
    .done_o     (done_a),
    .rd_data_o  (rd_a),
    .spi_sclk_o (sclk_a),
    .spi_mosi_o (mosi_a),
    .spi_cs_n_o (cs_a),
    .dc_o       (dc_a),
    .spi_miso_i (miso_v[0])
  );

  dfm_spi_master #(.RD_BYTES(2)) dut2 (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start_i    (start_b),
    .cmd_i      (cmd_b),
    .busy_o     (busy_b),
    .done_o     (done_b),
    .rd_data_o  (rd_b),
    .spi_sclk_o (sclk_b),
    .spi_mosi_o (mosi_b),
    .spi_cs_n_o (cs_b),
    .dc_o       (dc_b),
    .spi_miso_i (miso_v[1])
  );

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One slave-model step per DUT, evaluated at each falling sys_clk edge.
  task automatic slave_step();
    for (int i = 0; i < 2; i++) begin
      if (clr_req[i]) begin
        rise_cnt[i] = 0;
        fall_cnt[i] = 0;
        done_cnt[i] = 0;
        dc_err[i]   = 0;
        mosi_cap[i] = 8'h00;
        slv_data[i] = slv_word[i];
        miso_v[i]   = 1'b0;
      end else begin
        if (!prev_sclk[i] && sclk_w[i]) begin
          rise_cnt[i]++;
          if (rise_cnt[i] <= 8) mosi_cap[i] = {mosi_cap[i][6:0], mosi_w[i]};
          if ((rise_cnt[i] <= 8) == dc_w[i]) dc_err[i]++;
        end
        if (prev_sclk[i] && !sclk_w[i]) begin
          fall_cnt[i]++;
          if (fall_cnt[i] >= 8 && fall_cnt[i] < 72) miso_v[i] = slv_data[i][71 - fall_cnt[i]];
        end
        if (done_w[i]) done_cnt[i]++;
      end
      prev_sclk[i] = sclk_w[i];
    end
  endtask

  initial begin
    forever begin
      @(negedge sys_clk);
      slave_step();
    end
  end

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_cs(input int sel);
    return (sel == 0) ? cs_a : cs_b;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [63:0] get_rd(input int sel);
    return (sel == 0) ? rd_a : rd_b;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask
  task automatic set_cmd(input int sel, input logic [7:0] v);
    if (sel == 0) cmd_a = v;
    else          cmd_b = v;
  endtask

  task automatic clear_slave(input int sel, input logic [63:0] sdata);
    slv_word[sel] = sdata;
    clr_req[sel]  = 1'b1;
    @(negedge sys_clk); #1;
    clr_req[sel]  = 1'b0;
  endtask

  // Single transaction; cycle 0 is the acceptance cycle. Optional start re-pulse at cycle poke.
  task automatic run_txn(input int sel, input logic [7:0] cmd, input logic [63:0] sdata,
                         input int poke, output int done_at, output int dones,
                         output logic cs_at_done, output logic busy_after, output logic hold_ok);
    int cyc;
    int tail;
    logic [63:0] prev_rd;
    clear_slave(sel, sdata);
    @(posedge sys_clk); #2;
    set_cmd(sel, cmd);
    set_start(sel, 1'b1);
    prev_rd = get_rd(sel);
    @(posedge sys_clk); #2;
    set_start(sel, 1'b0);
    cyc = 1; done_at = -1; dones = 0; cs_at_done = 1'b0; busy_after = 1'b1; hold_ok = 1'b1; tail = -1;
    while (cyc < 2000 && tail != 0) begin
      @(negedge sys_clk); #1;
      if (get_done(sel)) begin
        dones++;
        if (done_at < 0) begin
          done_at    = cyc;
          cs_at_done = get_cs(sel);
          tail       = 8;
        end
      end else if (done_at < 0 && get_rd(sel) !== prev_rd) begin
        hold_ok = 1'b0;
      end
      if (done_at >= 0 && cyc == done_at + 1) busy_after = get_busy(sel);
      if (tail > 0) tail--;
      @(posedge sys_clk); #2;
      cyc++;
      set_start(sel, cyc == poke);
    end
  endtask

  initial begin
    int          done_at, dones, w, nd, cyc, d1, d2;
    logic        cs_d, busy_d, hold_ok;

    sys_rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00;
    clr_req = 2'b00;
    slv_word[0] = 64'd0; slv_word[1] = 64'd0;

    // reset values
    #23;
    chk_vec("rst_cs_n", cs_a, 1'b1);
    chk_vec("rst_sclk", sclk_a, 1'b0);
    chk_vec("rst_mosi", mosi_a, 1'b0);
    chk_vec("rst_dc",   dc_a, 1'b0);
    chk_vec("rst_busy", busy_a, 1'b0);
    chk_vec("rst_done", done_a, 1'b0);
    chk_vec("rst_rd",   rd_a, 64'd0);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);

    // full default read, cmd 0x3B
    run_txn(0, 8'h3B, 64'h0102030405060708, -1, done_at, dones, cs_d, busy_d, hold_ok);
    chk_vec("t1_mosi",  mosi_cap[0], 8'h3B);
    chk_vec("t1_rises", rise_cnt[0], 72);
    chk_vec("t1_dc",    dc_err[0], 0);
    chk_vec("t1_lat",   done_at, 597);
    chk_vec("t1_cs_at_done", cs_d, 1'b1);
    chk_vec("t1_rd",    rd_a, 64'h0102030405060708);
    chk_vec("t1_busy_after", busy_d, 1'b0);
    chk_vec("t1_dones", dones, 1);
    chk_vec("t1_rd_hold", hold_ok, 1'b1);

    // two-byte instance
    run_txn(1, 8'h5A, 64'hA55A000000000000, -1, done_at, dones, cs_d, busy_d, hold_ok);
    chk_vec("t2_mosi",  mosi_cap[1], 8'h5A);
    chk_vec("t2_rises", rise_cnt[1], 24);
    chk_vec("t2_dc",    dc_err[1], 0);
    chk_vec("t2_lat",   done_at, 213);
    chk_vec("t2_rd",    rd_b, 64'hA55A000000000000);
    chk_vec("t2_dones", dones, 1);

    // start re-pulsed mid-transaction is ignored
    run_txn(0, 8'hC3, 64'hDEADBEEFCAFEF00D, 100, done_at, dones, cs_d, busy_d, hold_ok);
    chk_vec("t3_mosi",  mosi_cap[0], 8'hC3);
    chk_vec("t3_rises", rise_cnt[0], 72);
    chk_vec("t3_lat",   done_at, 597);
    chk_vec("t3_dones", dones, 1);
    chk_vec("t3_rd",    rd_a, 64'hDEADBEEFCAFEF00D);
    chk_vec("t3_rd_hold", hold_ok, 1'b1);

    // reset during DATA bit 30
    clear_slave(0, 64'h1122334455667788);
    @(posedge sys_clk); #2;
    cmd_a = 8'h3B; start_a = 1'b1;
    @(posedge sys_clk); #2;
    start_a = 1'b0;
    w = 0;
    while (rise_cnt[0] < 39 && w < 2000) begin
      @(negedge sys_clk); #1;
      w++;
    end
    chk_vec("t4_reach_bit30", rise_cnt[0] >= 39, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk_vec("t4_cs_n", cs_a, 1'b1);
    chk_vec("t4_sclk", sclk_a, 1'b0);
    chk_vec("t4_rd",   rd_a, 64'd0);
    chk_vec("t4_done", done_a, 1'b0);
    chk_vec("t4_busy", busy_a, 1'b0);
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    nd = 0;
    repeat (700) begin
      @(negedge sys_clk); #1;
      if (done_a) nd++;
    end
    chk_vec("t4_no_done", nd, 0);
    run_txn(0, 8'h3B, 64'h8877665544332211, -1, done_at, dones, cs_d, busy_d, hold_ok);
    chk_vec("t4_after_lat", done_at, 597);
    chk_vec("t4_after_rd",  rd_a, 64'h8877665544332211);

    // back-to-back with start held high
    clear_slave(0, 64'hF0E1D2C3B4A59687);
    @(posedge sys_clk); #2;
    cmd_a = 8'h3B; start_a = 1'b1;
    @(posedge sys_clk); #2;
    cyc = 1; d1 = -1;
    while (d1 < 0 && cyc < 2000) begin
      @(negedge sys_clk); #1;
      if (done_a) d1 = cyc;
      else begin
        @(posedge sys_clk); #2;
        cyc++;
      end
    end
    chk_vec("t5_lat1", d1, 597);
    chk_vec("t5_cs_done", cs_a, 1'b1);
    slv_word[0] = 64'h0F1E2D3C4B5A6978;
    clr_req[0] = 1'b1;
    @(posedge sys_clk); #2;
    @(negedge sys_clk); #1;
    clr_req[0] = 1'b0;
    chk_vec("t5_cs_idle",   cs_a, 1'b1);
    chk_vec("t5_busy_idle", busy_a, 1'b0);
    @(posedge sys_clk); #2;
    start_a = 1'b0;
    @(negedge sys_clk); #1;
    chk_vec("t5_cs_setup",   cs_a, 1'b0);
    chk_vec("t5_busy_setup", busy_a, 1'b1);
    cyc = d1 + 2; d2 = -1;
    while (d2 < 0 && cyc < d1 + 2000) begin
      @(posedge sys_clk); #2;
      cyc++;
      @(negedge sys_clk); #1;
      if (done_a) d2 = cyc;
    end
    chk_vec("t5_lat2",  d2 - (d1 + 1), 597);
    chk_vec("t5_rises", rise_cnt[0], 72);
    chk_vec("t5_rd",    rd_a, 64'h0F1E2D3C4B5A6978);
    repeat (4) @(posedge sys_clk);
    #2;
    chk_vec("t5_idle_end", busy_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
